// File: rtl/fu_config_sequencer_if.sv
// Host-side context table write bus for the FU config sequencer.
// No latency of its own: plain wires between the host (master) and the sequencer (slave).
// No backpressure: writes offered while the sequencer is busy are dropped and flagged there.
interface fu_config_sequencer_if #(
  parameter int CONFIG_ALL = 64,
  parameter int ADDR_W     = 4,
  parameter int RPT_W      = 8
);
  logic                  cfg_we;
  logic [ADDR_W-1:0]     cfg_waddr;
  logic [CONFIG_ALL-1:0] cfg_wdata;
  logic [RPT_W-1:0]      cfg_wrpt;
  logic                  cfg_wlast;

  modport master (output cfg_we, cfg_waddr, cfg_wdata, cfg_wrpt, cfg_wlast);
  modport slave  (input  cfg_we, cfg_waddr, cfg_wdata, cfg_wrpt, cfg_wlast);
endinterface

// File: rtl/fu_config_sequencer.sv
// Context sequencer replaying a DEPTH-entry table of FU config words, each held rpt+1 cycles.
// Latency: start sampled in cycle N puts the first entry on config_all_o in cycle N+1; all outputs registered.
// Backpressure: stall freezes pc/repeat count and drives NOP; abort returns to IDLE. Optional macro FU_SEQ_LOOP_EN.
module fu_config_sequencer #(
  parameter int CONFIG_ALL = 64,
  parameter int DEPTH      = 16,
  parameter int RPT_W      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  fu_config_sequencer_if.slave  cfg_if,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
`ifdef FU_SEQ_LOOP_EN
  input  logic [7:0]            loop_cnt,
`endif
  input  logic                  stall,
  input  logic                  abort,
  output logic [CONFIG_ALL-1:0] config_all_o,
  output logic                  cfg_valid_o,
  output logic [ADDR_W-1:0]     pc_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CONFIG_ALL-1:0] config_q, config_d;
  logic                  valid_q, valid_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [RPT_W-1:0]      rpt_q, rpt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Context table: deliberately not reset, the host always loads it before use.
  logic [CONFIG_ALL-1:0] tbl_data_q [DEPTH];
  logic [RPT_W-1:0]      tbl_rpt_q  [DEPTH];
  logic [DEPTH-1:0]      tbl_last_q;

  logic                  tbl_we;
  logic                  fwd;
  logic [CONFIG_ALL-1:0] first_data;
  logic [RPT_W-1:0]      first_rpt;
  logic                  cur_last;
  logic [ADDR_W-1:0]     pc_inc;
  logic [ADDR_W-1:0]     nxt_pc;
  logic                  loop_more;
  logic                  adv;
  logic                  fin;

  // Writes only land while idle; anything offered mid-program is dropped.
  assign tbl_we = cfg_if.cfg_we && (state_q == S_IDLE);

  // A write to the start address in the start cycle must be seen by the first entry.
  assign fwd        = cfg_if.cfg_we && (cfg_if.cfg_waddr == start_addr);
  assign first_data = fwd ? cfg_if.cfg_wdata : tbl_data_q[start_addr];
  assign first_rpt  = fwd ? cfg_if.cfg_wrpt  : tbl_rpt_q[start_addr];

  assign cur_last = tbl_last_q[pc_q];
  assign pc_inc   = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);

`ifdef FU_SEQ_LOOP_EN
  logic [7:0]        loops_q, loops_d;
  logic [ADDR_W-1:0] base_q, base_d;

  assign loop_more = (loops_q != 8'd0);
  assign nxt_pc    = (cur_last && loop_more) ? base_q : pc_inc;
`else
  assign loop_more = 1'b0;
  assign nxt_pc    = pc_inc;
`endif

  // adv: current entry has used its last active cycle and the sequencer may move on.
  assign adv = (state_q == S_RUN) && !abort && !stall && (rpt_q == '0);
  assign fin = adv && cur_last && !loop_more;

  // Table write port.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_data_q[cfg_if.cfg_waddr] <= cfg_if.cfg_wdata;
      tbl_rpt_q[cfg_if.cfg_waddr]  <= cfg_if.cfg_wrpt;
      tbl_last_q[cfg_if.cfg_waddr] <= cfg_if.cfg_wlast;
    end
  end

  // State and registered outputs; reset wins over everything, including abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      config_q <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rpt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      config_q <= config_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rpt_q    <= rpt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next state: abort beats completion; DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)    state_d = S_IDLE;
        else if (fin) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath: NOP unless a live entry is presented; stall holds pc and count.
  always_comb begin
    config_d = '0;
    valid_d  = 1'b0;
    pc_d     = pc_q;
    rpt_d    = rpt_q;
    done_d   = 1'b0;
    err_d    = cfg_if.cfg_we && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d     = start_addr;
          rpt_d    = first_rpt;
          config_d = first_data;
          valid_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (!abort && !stall) begin
          if (rpt_q != '0) begin
            config_d = tbl_data_q[pc_q];
            valid_d  = 1'b1;
            rpt_d    = rpt_q - RPT_W'(1);
          end else if (fin) begin
            done_d = 1'b1;
          end else begin
            pc_d     = nxt_pc;
            config_d = tbl_data_q[nxt_pc];
            rpt_d    = tbl_rpt_q[nxt_pc];
            valid_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef FU_SEQ_LOOP_EN
  // Loop bookkeeping: capture pass count and restart address with start.
  always_comb begin
    loops_d = loops_q;
    base_d  = base_q;
    if ((state_q == S_IDLE) && start) begin
      loops_d = loop_cnt;
      base_d  = start_addr;
    end else if (adv && cur_last && loop_more) begin
      loops_d = loops_q - 8'd1;
    end
  end

  // Loop registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      loops_q <= 8'd0;
      base_q  <= '0;
    end else begin
      loops_q <= loops_d;
      base_q  <= base_d;
    end
  end
`endif

  assign config_all_o = config_q;
  assign cfg_valid_o  = valid_q;
  assign pc_o         = pc_q;
  assign busy_o       = (state_q == S_RUN);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fu_config_sequencer.sv
// Directed bench for fu_config_sequencer: per-cycle vector table plus hand-written long-repeat and loop sequences.
// Vector i: outputs expected during cycle i, inputs driven during cycle i (sampled at its closing edge).
// Outputs sampled on the falling edge, inputs changed right after sampling.
module tb_fu_config_sequencer;

  localparam int KI = 0;  // idle: NOP, not busy
  localparam int KL = 1;  // live entry
  localparam int KS = 2;  // stalled: NOP, busy, pc frozen
  localparam int KD = 3;  // done pulse
  localparam int KZ = 4;  // reset state, pc checked as 0

  localparam logic [63:0] D0  = 64'h1000_0000_0000_00A0;
  localparam logic [63:0] D1  = 64'h2000_0000_0000_00A1;
  localparam logic [63:0] D2  = 64'h3000_0000_0000_00A2;
  localparam logic [63:0] D15 = 64'h4000_0000_0000_00AF;
  localparam logic [63:0] D0B = 64'h5000_0000_0000_00B0;
  localparam logic [63:0] DF  = 64'h6000_0000_0000_00F0;
  localparam logic [63:0] BAD = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] D7  = 64'h7000_0000_0000_0007;

  typedef struct {
    bit          rst;
    bit          start;
    bit          stall;
    bit          abort;
    logic [3:0]  sa;
    bit          we;
    logic [3:0]  wa;
    logic [63:0] wd;
    logic [7:0]  wr;
    bit          wl;
    int          kind;
    logic [63:0] d;
    logic [3:0]  pc;
    bit          er;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  start_addr;
  logic        stall;
  logic        abort;
  logic [63:0] config_all_o;
  logic        cfg_valid_o;
  logic [3:0]  pc_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
`ifdef FU_SEQ_LOOP_EN
  logic [7:0]  loop_cnt;
`endif

  int n_pass;
  int n_chk;
  int cur_vec;
  vec_t vq[$];

  fu_config_sequencer_if #(.CONFIG_ALL(64), .ADDR_W(4), .RPT_W(8)) cif ();

  fu_config_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_if       (cif),
    .start        (start),
    .start_addr   (start_addr),
`ifdef FU_SEQ_LOOP_EN
    .loop_cnt     (loop_cnt),
`endif
    .stall        (stall),
    .abort        (abort),
    .config_all_o (config_all_o),
    .cfg_valid_o  (cfg_valid_o),
    .pc_o         (pc_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @vec %0d: got %0h expected %0h", nm, cur_vec, act, exp);
  endtask

  function automatic vec_t mk(input int kind, input logic [63:0] d, input logic [3:0] pc);
    vec_t x;
    x = '{default: 0};
    x.kind = kind;
    x.d    = d;
    x.pc   = pc;
    return x;
  endfunction

  function automatic vec_t f_idle();
    return mk(KI, 64'd0, 4'd0);
  endfunction

  function automatic vec_t f_live(input logic [63:0] d, input logic [3:0] pc);
    return mk(KL, d, pc);
  endfunction

  function automatic vec_t f_start(input vec_t x, input logic [3:0] sa);
    x.start = 1'b1;
    x.sa    = sa;
    return x;
  endfunction

  function automatic vec_t f_wr(input vec_t x, input logic [3:0] a, input logic [63:0] dd,
                                input logic [7:0] r, input bit l);
    x.we = 1'b1;
    x.wa = a;
    x.wd = dd;
    x.wr = r;
    x.wl = l;
    return x;
  endfunction

  function automatic vec_t f_stall(input vec_t x);
    x.stall = 1'b1;
    return x;
  endfunction

  function automatic vec_t f_abort(input vec_t x);
    x.abort = 1'b1;
    return x;
  endfunction

  function automatic vec_t f_rst(input vec_t x);
    x.rst = 1'b1;
    return x;
  endfunction

  function automatic vec_t f_err(input vec_t x);
    x.er = 1'b1;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    rst           = x.rst;
    start         = x.start;
    start_addr    = x.sa;
    stall         = x.stall;
    abort         = x.abort;
    cif.cfg_we    = x.we;
    cif.cfg_waddr = x.wa;
    cif.cfg_wdata = x.wd;
    cif.cfg_wrpt  = x.wr;
    cif.cfg_wlast = x.wl;
  endtask

  task automatic check_vec(input vec_t x);
    logic [63:0] ecfg;
    logic        evld, ebusy, edone, chkpc;
    ecfg = 64'd0; evld = 1'b0; ebusy = 1'b0; edone = 1'b0; chkpc = 1'b0;
    case (x.kind)
      KL: begin ecfg = x.d; evld = 1'b1; ebusy = 1'b1; chkpc = 1'b1; end
      KS: begin ebusy = 1'b1; chkpc = 1'b1; end
      KD: edone = 1'b1;
      KZ: chkpc = 1'b1;
      default: ;
    endcase
    chk("config_all", config_all_o, ecfg);
    chk("cfg_valid", {63'd0, cfg_valid_o}, {63'd0, evld});
    chk("busy", {63'd0, busy_o}, {63'd0, ebusy});
    chk("done", {63'd0, done_o}, {63'd0, edone});
    chk("err", {63'd0, err_o}, {63'd0, x.er});
    if (chkpc) chk("pc", {60'd0, pc_o}, {60'd0, x.pc});
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    cur_vec = -1;
    drive(f_rst(f_idle()));
`ifdef FU_SEQ_LOOP_EN
    loop_cnt = 8'd0;
`endif

    // Load e0(rpt0), e1(rpt2), e2(rpt0,last); first check sees the reset state.
    vq.push_back(f_wr(mk(KZ, 64'd0, 4'd0), 4'd0, D0, 8'd0, 1'b0));
    vq.push_back(f_wr(f_idle(), 4'd1, D1, 8'd2, 1'b0));
    vq.push_back(f_wr(f_idle(), 4'd2, D2, 8'd0, 1'b1));
    // Plain run: e0@1, e1@2-4, e2@5, done@6, idle@7.
    vq.push_back(f_start(f_idle(), 4'd0));
    vq.push_back(f_live(D0, 4'd0));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D2, 4'd2));
    vq.push_back(mk(KD, 64'd0, 4'd0));
    vq.push_back(f_idle());
    // Stall inputs in cycles 2-3 give NOP outputs in 3-4; e1 resumes 5-6, e2@7, done@8.
    vq.push_back(f_start(f_idle(), 4'd0));
    vq.push_back(f_live(D0, 4'd0));
    vq.push_back(f_stall(f_live(D1, 4'd1)));
    vq.push_back(f_stall(mk(KS, 64'd0, 4'd1)));
    vq.push_back(mk(KS, 64'd0, 4'd1));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D2, 4'd2));
    vq.push_back(mk(KD, 64'd0, 4'd0));
    vq.push_back(f_idle());
    // Wrap: addr 15 (not last) then addr 0 (rpt1, last).
    vq.push_back(f_wr(f_idle(), 4'd15, D15, 8'd0, 1'b0));
    vq.push_back(f_wr(f_idle(), 4'd0, D0B, 8'd1, 1'b1));
    vq.push_back(f_start(f_idle(), 4'd15));
    vq.push_back(f_live(D15, 4'd15));
    vq.push_back(f_live(D0B, 4'd0));
    vq.push_back(f_live(D0B, 4'd0));
    vq.push_back(mk(KD, 64'd0, 4'd0));
    vq.push_back(f_idle());
    // Write during RUN is dropped and flagged; abort during e1; rerun proves table intact.
    vq.push_back(f_wr(f_idle(), 4'd0, D0, 8'd0, 1'b0));
    vq.push_back(f_start(f_idle(), 4'd0));
    vq.push_back(f_live(D0, 4'd0));
    vq.push_back(f_wr(f_live(D1, 4'd1), 4'd1, BAD, 8'd0, 1'b1));
    vq.push_back(f_abort(f_err(f_live(D1, 4'd1))));
    vq.push_back(f_idle());
    vq.push_back(f_idle());
    vq.push_back(f_start(f_idle(), 4'd0));
    vq.push_back(f_live(D0, 4'd0));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D2, 4'd2));
    vq.push_back(mk(KD, 64'd0, 4'd0));
    vq.push_back(f_idle());
    // Reset mid-RUN, then a normal run.
    vq.push_back(f_start(f_idle(), 4'd0));
    vq.push_back(f_live(D0, 4'd0));
    vq.push_back(f_rst(f_live(D1, 4'd1)));
    vq.push_back(mk(KZ, 64'd0, 4'd0));
    vq.push_back(f_start(f_idle(), 4'd0));
    vq.push_back(f_live(D0, 4'd0));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D1, 4'd1));
    vq.push_back(f_live(D2, 4'd2));
    vq.push_back(mk(KD, 64'd0, 4'd0));
    vq.push_back(f_idle());
    // Write forwarded into the first entry; abort together with stall returns to idle.
    vq.push_back(f_wr(f_start(f_idle(), 4'd0), 4'd0, DF, 8'd0, 1'b0));
    vq.push_back(f_live(DF, 4'd0));
    vq.push_back(f_stall(f_abort(f_live(D1, 4'd1))));
    vq.push_back(f_idle());
    vq.push_back(f_idle());

    repeat (3) @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      cur_vec = i;
      check_vec(vq[i]);
      drive(vq[i]);
      @(negedge clk);
    end
    cur_vec = -1;

    // Long repeat: rpt=20 gives 21 live cycles, done 22 cycles after start (bounded wait).
    begin
      bit seen;
      int nv;
      int lat;
      vec_t x;
      seen = 1'b0; nv = 0; lat = 0;
      drive(f_wr(f_idle(), 4'd7, D7, 8'd20, 1'b1));
      @(negedge clk);
      drive(f_start(f_idle(), 4'd7));
      @(negedge clk);
      drive(f_idle());
      chk("long_first_data", config_all_o, D7);
      for (int k = 1; k <= 60 && !seen; k++) begin
        if (done_o) begin
          seen = 1'b1;
          lat  = k;
        end else begin
          if (cfg_valid_o) nv++;
          @(negedge clk);
        end
      end
      chk("long_done_seen", {63'd0, seen}, 64'd1);
      chk("long_live_cycles", 64'(nv), 64'd21);
      chk("long_done_latency", 64'(lat), 64'd22);
      x = f_idle();
      @(negedge clk);
      check_vec(x);
    end

`ifdef FU_SEQ_LOOP_EN
    // Two-entry program looped three passes back to back, single done pulse.
    begin
      logic [63:0] ec [8];
      logic        ed [8];
      ec[0] = 64'h0000_0000_0000_00C4; ec[1] = 64'h0000_0000_0000_00C5;
      ec[2] = 64'h0000_0000_0000_00C4; ec[3] = 64'h0000_0000_0000_00C5;
      ec[4] = 64'h0000_0000_0000_00C4; ec[5] = 64'h0000_0000_0000_00C5;
      ec[6] = 64'd0;                   ec[7] = 64'd0;
      for (int k = 0; k < 8; k++) ed[k] = (k == 6);
      drive(f_wr(f_idle(), 4'd4, 64'h0000_0000_0000_00C4, 8'd0, 1'b0));
      @(negedge clk);
      drive(f_wr(f_idle(), 4'd5, 64'h0000_0000_0000_00C5, 8'd0, 1'b1));
      @(negedge clk);
      drive(f_start(f_idle(), 4'd4));
      loop_cnt = 8'd2;
      @(negedge clk);
      drive(f_idle());
      loop_cnt = 8'd0;
      for (int k = 0; k < 8; k++) begin
        chk("loop_config", config_all_o, ec[k]);
        chk("loop_done", {63'd0, done_o}, {63'd0, ed[k]});
        @(negedge clk);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
